// File: rtl/direction_deque.sv
// Purpose: 2-bit direction deque (LIFO backtrack at the back, FIFO path replay at the front) in a circular buffer.
// Latency: one cycle; stack_out/path_out/path_valid/err are registered, flags are decoded from count.
// Backpressure: none; illegal or dropped operations leave state untouched and set the sticky err flag.
module direction_deque #(
    parameter int DEPTH = 256
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     our_reset,
    input  logic                     push,
    input  logic [1:0]               dir,
    input  logic                     pop_back,
    input  logic                     pop_front,
    output logic [1:0]               stack_out,
    output logic [1:0]               path_out,
    output logic                     path_valid,
    output logic                     is_deque_empty,
    output logic                     is_deque_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage is deliberately not reset; a slot is only read after it was written.
    logic [1:0]    mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    stack_q, stack_d;
    logic [1:0]    path_q, path_d;
    logic          pvld_q, pvld_d;
    logic          err_q, err_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic          empty;
    logic          full;
    logic [AW-1:0] tail_m1;
    logic [AW-1:0] tail_p1;
    logic [AW-1:0] head_p1;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign tail_m1 = tail_q - AW'(1);
    assign tail_p1 = tail_q + AW'(1);
    assign head_p1 = head_q + AW'(1);

    // Next-state decode: our_reset first, then the operation combinations in priority order.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stack_d = stack_q;
        path_d  = path_q;
        pvld_d  = 1'b0;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = tail_q;
        if (our_reset) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stack_d = '0;
            path_d  = '0;
            err_d   = 1'b0;
        end else if (pop_back && pop_front) begin
            // Conflicting pops: the backtrack wins, any push is ignored.
            err_d = 1'b1;
            if (!empty) begin
                tail_d  = tail_m1;
                count_d = count_q - CW'(1);
                stack_d = mem[tail_m1];
            end
        end else if (push && pop_back) begin
            if (empty) begin
                // Bypass: the pushed direction comes straight back, nothing stored.
                stack_d = dir;
            end else begin
                // Swap the back entry in place; pointers and count stay put.
                stack_d = mem[tail_m1];
                we      = 1'b1;
                waddr   = tail_m1;
            end
        end else if (push && pop_front) begin
            we     = 1'b1;
            tail_d = tail_p1;
            if (empty) begin
                count_d = count_q + CW'(1);
                err_d   = 1'b1;
            end else begin
                // When full, head == tail: the read sees the old slot value before the write lands.
                path_d = mem[head_q];
                head_d = head_p1;
                pvld_d = 1'b1;
            end
        end else if (push) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                we      = 1'b1;
                tail_d  = tail_p1;
                count_d = count_q + CW'(1);
            end
        end else if (pop_back) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                tail_d  = tail_m1;
                count_d = count_q - CW'(1);
                stack_d = mem[tail_m1];
            end
        end else if (pop_front) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                path_d  = mem[head_q];
                head_d  = head_p1;
                count_d = count_q - CW'(1);
                pvld_d  = 1'b1;
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stack_q <= '0;
            path_q  <= '0;
            pvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stack_q <= stack_d;
            path_q  <= path_d;
            pvld_q  <= pvld_d;
            err_q   <= err_d;
        end
    end

    // Storage write port; suppressed while Rst is held so no partial update survives reset.
    always_ff @(posedge Clk) begin
        if (we && Rst) begin
            mem[waddr] <= dir;
        end
    end

    assign stack_out      = stack_q;
    assign path_out       = path_q;
    assign path_valid     = pvld_q;
    assign count          = count_q;
    assign err            = err_q;
    assign is_deque_empty = empty;
    assign is_deque_full  = full;

endmodule

// File: doc/direction_deque.md
DIRECTION_DEQUE -- requirements
Module: direction_deque

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 2-bit direction entries; power of two, at least 4.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port our_reset, input, 1, synchronous clear from the maze controller.
REQ-005 SHALL have port push, input, 1, write dir at the back.
REQ-006 SHALL have port dir, input, 2, direction code: 00 up, 01 right, 10 left, 11 down.
REQ-007 SHALL have port pop_back, input, 1, remove the back entry (backtracking, LIFO).
REQ-008 SHALL have port pop_front, input, 1, remove the front entry (path replay, FIFO).
REQ-009 SHALL have port stack_out, output, 2, last entry removed by pop_back; registered.
REQ-010 SHALL have port path_out, output, 2, last entry removed by pop_front; registered.
REQ-011 SHALL have port path_valid, output, 1, one-cycle pulse; path_out was updated at the preceding edge.
REQ-012 SHALL have port is_deque_empty, output, 1, count == 0.
REQ-013 SHALL have port is_deque_full, output, 1, count == DEPTH.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, current number of entries.
REQ-015 SHALL have port err, output, 1, sticky: an operation was dropped or was illegal.

Function
REQ-016 SHALL store entries in a circular buffer addressed by head (front) and tail (next free back slot) pointers of width log2(DEPTH). The pointers wrap modulo DEPTH with no special casing.
REQ-017 SHALL derive is_deque_empty and is_deque_full combinationally from count only.
REQ-018 push alone, not full: SHALL write dir at tail, advance tail by 1 and increment count.
REQ-019 pop_back alone, not empty: SHALL decrement tail and count, and load stack_out with mem[tail-1].
- stack_out is valid from the next cycle, when the controller samples it in its Pop_stack state.
REQ-020 pop_front alone, not empty: SHALL load path_out with mem[head], advance head, decrement count and pulse path_valid for exactly one cycle.
REQ-021 SHALL treat our_reset as highest priority. It clears head, tail, count, stack_out, path_out, path_valid and err, and ignores all other inputs that cycle.
REQ-022 push with pop_back, not empty:
- stack_out SHALL take the old back entry.
- dir SHALL overwrite that slot.
- tail and count SHALL be unchanged.
REQ-023 push with pop_back, empty: SHALL bypass, so stack_out = dir; count stays 0 and memory is not written.
REQ-024 push with pop_front, not empty: SHALL perform both operations and leave count unchanged. This includes the full case.
REQ-025 push with pop_front, empty: SHALL service the push only, leave path_valid low and set err.
REQ-026 pop_back with pop_front in the same cycle: SHALL service pop_back only and set err.
REQ-027 push when full, with no pop: SHALL drop the push, change no state and set err.
REQ-028 pop_back or pop_front when empty, with no push: SHALL change no state, hold stack_out and path_out, keep path_valid low and set err.
REQ-029 SHALL keep err set until Rst or our_reset.
REQ-030 SHALL write dir on the clock edge, using no combinational read path from dir to any output.

Reset
REQ-031 While Rst is low, SHALL force all outputs to their reset values regardless of Clk:
- head, tail, count = 0
- stack_out = 00, path_out = 00
- path_valid = 0, err = 0
- is_deque_empty = 1, is_deque_full = 0
REQ-032 SHALL leave the storage array uninitialised by reset; no entry is readable before it is written.
REQ-033 Rst asserted mid-operation SHALL abandon the in-flight operation, with no partial pointer update visible after release.

Verification
REQ-034 Bench SHALL push 00,01,01,11, then pop_back x2 -> stack_out reads 11 then 01, and count = 2.
REQ-035 Bench SHALL push 00,01,10, then pop_front x3 -> path_out 00,01,10, with 3 single-cycle path_valid pulses, then is_deque_empty = 1.
REQ-036 With DEPTH=4, bench SHALL push 4 entries and then push 11 -> is_deque_full = 1, count = 4, err = 1, contents unchanged. Then pop_front x2 and push x2 -> pointers wrap and the FIFO order is preserved.
REQ-037 On an empty deque, bench SHALL assert pop_back -> stack_out held, err = 1. Then push=1 with dir=10 and pop_back=1 -> stack_out = 10, count = 0.
REQ-038 With 3 entries, bench SHALL assert push=1 and pop_back=1 with dir=11 -> stack_out = old back entry, count = 3, and the next pop_back returns 11.
REQ-039 With 5 entries, bench SHALL pulse Rst low asynchronously between edges -> count = 0, is_deque_empty = 1 and err = 0 immediately. Then our_reset after pushes -> count = 0 at the next edge.
